uart_rx_majority_sampler: RTL and testbench

//  Parametrised UART RX oversampling bit sampler: captures SAMPLES copies of rx_in centred
//  on the bit midpoint and resolves them by majority vote. Emits a one-cycle bit_valid strobe

---
 rtl/uart_rx_majority_sampler.sv | 133 +++++++++++++
 tb/tb_uart_rx_majority_sampler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_majority_sampler.sv
// UART RX oversampling bit sampler: takes SAMPLES votes centred on the bit midpoint and
// resolves them by majority, flagging disagreement as noise.
module uart_rx_majority_sampler #(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned SAMPLES        = 3
) (
  input  logic                      rx_clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic                      rx_in,
  output logic                      sampled_bit,
  output logic                      bit_valid,
  output logic                      noise_flag,
  output logic                      cfg_err
);

  localparam int unsigned ExtW        = PRESCALE_WIDTH + 1;
  localparam int unsigned CntW        = $clog2(SAMPLES + 1);
  localparam int unsigned HalfWin     = (SAMPLES - 1) / 2;
  localparam int unsigned MinPrescale = 2 * SAMPLES + 2;

  if (((SAMPLES % 2) == 0) || (SAMPLES > 7)) begin : gen_bad_samples
    $error("SAMPLES must be odd and within 1..7");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDecide
  } state_e;

  localparam state_e FirstNext = (SAMPLES == 1) ? StDecide : StCollect;

  state_e                      state_q;
  logic   [CntW-1:0]           cnt_q;
  logic   [SAMPLES-1:0]        shreg_q;
  logic   [PRESCALE_WIDTH-1:0] last_edge_q;
  logic                        armed_q;

  logic [ExtW-1:0]    mid;
  logic [ExtW-1:0]    edge_ext;
  logic               in_win;
  logic               cfg_bad;
  logic               active;
  logic               take;
  logic [CntW-1:0]    popcnt;
  logic               vote;
  logic               noisy;
  logic [SAMPLES-1:0] shreg_shift;
  logic [CntW-1:0]    cnt_inc;

  // Window test adds HalfWin on the edge side so the lower bound never underflows.
  always_comb begin
    mid      = {1'b0, prescale} >> 1;
    edge_ext = {1'b0, edge_cnt};
    in_win   = ((edge_ext + ExtW'(HalfWin)) >= mid) && (edge_ext <= (mid + ExtW'(HalfWin)));
    cfg_bad  = {1'b0, prescale} < ExtW'(MinPrescale);
    active   = enable && !cfg_bad && !cfg_err;
    // A stalled edge counter must not add votes: sample only on a new index.
    take     = active && in_win && (!armed_q || (edge_cnt != last_edge_q));
  end

  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < SAMPLES; i++) begin
      popcnt = popcnt + CntW'(shreg_q[i]);
    end
    vote        = popcnt > CntW'(SAMPLES / 2);
    noisy       = (popcnt != '0) && (popcnt != CntW'(SAMPLES));
    shreg_shift = (shreg_q << 1) | SAMPLES'(rx_in);
    cnt_inc     = cnt_q + CntW'(1);
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      last_edge_q <= '0;
      armed_q     <= 1'b0;
      sampled_bit <= 1'b0;
      bit_valid   <= 1'b0;
      noise_flag  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err     <= cfg_bad;
      bit_valid   <= 1'b0;
      last_edge_q <= edge_cnt;
      armed_q     <= active && in_win;
      if (!active) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (take) begin
              shreg_q <= shreg_shift;
              cnt_q   <= CntW'(1);
              state_q <= FirstNext;
            end
          end
          StCollect: begin
            if (edge_cnt == '0) begin
              // Bit boundary reached with a partial window: drop it silently.
              cnt_q   <= '0;
              state_q <= StIdle;
            end else if (take) begin
              shreg_q <= shreg_shift;
              cnt_q   <= cnt_inc;
              if (cnt_inc == CntW'(SAMPLES)) begin
                state_q <= StDecide;
              end
            end
          end
          StDecide: begin
            sampled_bit <= vote;
            noise_flag  <= noisy;
            bit_valid   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end
          default: begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_majority_sampler.sv
// Directed bench for uart_rx_majority_sampler with SAMPLES=3 and SAMPLES=5 instances.
module tb_uart_rx_majority_sampler;

  localparam int PW = 6;

  logic          rx_clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic [PW-1:0] p5;
  logic [PW-1:0] edge_cnt;
  logic          sb3, bv3, nf3, ce3;
  logic          sb5, bv5, nf5, ce5;

  int compared   = 0;
  int mismatched = 0;

  always #5 rx_clk = ~rx_clk;

  uart_rx_majority_sampler #(.PRESCALE_WIDTH(PW), .SAMPLES(3)) dut3 (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (prescale),
    .edge_cnt   (edge_cnt),
    .rx_in      (rx_in),
    .sampled_bit(sb3),
    .bit_valid  (bv3),
    .noise_flag (nf3),
    .cfg_err    (ce3)
  );

  uart_rx_majority_sampler #(.PRESCALE_WIDTH(PW), .SAMPLES(5)) dut5 (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (p5),
    .edge_cnt   (edge_cnt),
    .rx_in      (rx_in),
    .sampled_bit(sb5),
    .bit_valid  (bv5),
    .noise_flag (nf5),
    .cfg_err    (ce5)
  );

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // One bit period; window [lo, lo+n) carries smp[0..n-1]. The strobe (or its absence) and
  // the resulting output values are checked in the cycle after the last window index.
  task automatic send_bit(input int which, input int p, input int lo, input int n,
                          input logic [6:0] smp, input logic xs, input logic eb,
                          input logic en);
    logic v, b, f;
    for (int e = 0; e < p; e++) begin
      edge_cnt = PW'(e);
      rx_in    = (e >= lo && e < lo + n) ? smp[e-lo] : 1'b0;
      tick();
      v = (which == 5) ? bv5 : bv3;
      b = (which == 5) ? sb5 : sb3;
      f = (which == 5) ? nf5 : nf3;
      if (e == lo + n) begin
        chk("strobe", v, xs);
        chk("bit", b, eb);
        chk("noise", f, en);
      end else begin
        chk("no_strobe", v, 1'b0);
      end
    end
  endtask

  initial begin
    logic [PW-1:0] ec_tab [10];
    logic          rv_tab [10];

    rst      = 1'b1;
    enable   = 1'b0;
    prescale = 8;
    p5       = 16;
    edge_cnt = '0;
    rx_in    = 1'b0;
    tick();
    tick();
    chk("rst_bit3", sb3, 1'b0);
    chk("rst_valid3", bv3, 1'b0);
    chk("rst_noise3", nf3, 1'b0);
    chk("rst_cfg3", ce3, 1'b0);
    chk("rst_bit5", sb5, 1'b0);
    chk("rst_valid5", bv5, 1'b0);
    rst    = 1'b0;
    enable = 1'b1;

    // Majority votes, prescale 8 -> window 3..5
    send_bit(3, 8, 3, 3, 7'b0000111, 1'b1, 1'b1, 1'b0);
    send_bit(3, 8, 3, 3, 7'b0000101, 1'b1, 1'b1, 1'b1);
    send_bit(3, 8, 3, 3, 7'b0000100, 1'b1, 1'b0, 1'b1);
    send_bit(3, 8, 3, 3, 7'b0000000, 1'b1, 1'b0, 1'b0);
    send_bit(3, 8, 3, 3, 7'b0000111, 1'b1, 1'b1, 1'b0);

    // Enable dropped after the second sample: no strobe, sampled_bit holds 1
    for (int e = 0; e < 5; e++) begin
      edge_cnt = PW'(e);
      rx_in    = 1'b0;
      tick();
      chk("abort_pre", bv3, 1'b0);
    end
    enable = 1'b0;
    for (int e = 5; e < 8; e++) begin
      edge_cnt = PW'(e);
      tick();
      chk("abort_valid", bv3, 1'b0);
      chk("abort_hold", sb3, 1'b1);
    end
    enable = 1'b1;
    send_bit(3, 8, 3, 3, 7'b0000000, 1'b1, 1'b0, 1'b0);

    // Enable low during DECIDE suppresses the strobe
    for (int e = 0; e < 6; e++) begin
      edge_cnt = PW'(e);
      rx_in    = 1'b1;
      tick();
      chk("dec_pre", bv3, 1'b0);
    end
    edge_cnt = 6;
    enable   = 1'b0;
    tick();
    chk("dec_valid", bv3, 1'b0);
    chk("dec_hold_bit", sb3, 1'b0);
    chk("dec_hold_noise", nf3, 1'b0);
    edge_cnt = 7;
    enable   = 1'b1;
    tick();
    chk("dec_after", bv3, 1'b0);

    // Config error: 7 is just below the minimum of 8
    prescale = 7;
    edge_cnt = 0;
    tick();
    chk("cfg_p7", ce3, 1'b1);
    prescale = 6;
    for (int k = 0; k < 3; k++) begin
      send_bit(3, 6, 2, 3, 7'b0000111, 1'b0, 1'b0, 1'b0);
      chk("cfg_p6", ce3, 1'b1);
    end
    prescale = 8;
    edge_cnt = 0;
    tick();
    chk("cfg_p8", ce3, 1'b0);
    send_bit(3, 8, 3, 3, 7'b0000111, 1'b1, 1'b1, 1'b0);
    send_bit(3, 8, 3, 3, 7'b0000101, 1'b1, 1'b1, 1'b1);

    // Reset in COLLECT clears outputs; the stray partial window after it is discarded
    for (int e = 0; e < 4; e++) begin
      edge_cnt = PW'(e);
      rx_in    = 1'b1;
      tick();
      chk("rc_pre", bv3, 1'b0);
    end
    edge_cnt = 4;
    rst      = 1'b1;
    tick();
    chk("rc_bit", sb3, 1'b0);
    chk("rc_valid", bv3, 1'b0);
    chk("rc_noise", nf3, 1'b0);
    chk("rc_cfg", ce3, 1'b0);
    rst = 1'b0;
    for (int e = 5; e < 8; e++) begin
      edge_cnt = PW'(e);
      tick();
      chk("rc_post", bv3, 1'b0);
    end

    // Edge counter stalled at 4: votes are 1 (at 3), 0 (at 4), 0 (at 5)
    ec_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd4, 6'd4, 6'd5, 6'd6, 6'd7};
    rv_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      edge_cnt = ec_tab[i];
      rx_in    = rv_tab[i];
      tick();
      if (i == 8) begin
        chk("stall_strobe", bv3, 1'b1);
        chk("stall_bit", sb3, 1'b0);
        chk("stall_noise", nf3, 1'b1);
      end else begin
        chk("stall_no_strobe", bv3, 1'b0);
      end
    end

    // SAMPLES=5, prescale 16 -> window 6..10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_bit(5, 16, 6, 5, 7'b0000011, 1'b1, 1'b0, 1'b1);
    send_bit(5, 16, 6, 5, 7'b0001101, 1'b1, 1'b1, 1'b1);
    send_bit(5, 16, 6, 5, 7'b0011111, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
